// File: rtl/md_pkg.sv
// md_pkg: shared md_op encodings, default latencies and md_unit state type
package md_pkg;
  localparam int MD_OP_W = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;
  typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;
endpackage

// File: rtl/md_unit.sv
// md_unit: EX-stage multi-cycle MULT/DIV unit owning HI/LO
// Ports: clk, reset (sync, active-high); md_op/src_a/src_b from EX;
//   start (issue this cycle), busy (op in flight), hi/lo registers,
//   md_out (MFHI/MFLO read data, else 0).
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  output logic               start,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic [31:0]        md_out
);
  md_state_e state, state_nx;
  logic [15:0] cnt;
  logic [31:0] pend_hi, pend_lo;
  logic pend_wr;
  logic is_mul, is_div;
  logic signed [63:0] ea, eb;
  logic [63:0] smul, umul;
  logic [31:0] dv, ds, sq, sr, uq, ur, res_hi, res_lo;
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == ST_IDLE && start) state_nx = ST_BUSY;
    if (state == ST_BUSY && cnt == 16'd1) state_nx = ST_IDLE;
  end
  always_comb begin
    busy = state == ST_BUSY;
    start = (is_mul || is_div) && !busy;
    md_out = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : 32'd0;
  end
  // Divisors of 0 and the signed 0x80000000/-1 overflow are replaced by 1:
  // the former keeps the datapath X-free (result is discarded anyway), the
  // latter yields exactly quotient 0x80000000, remainder 0.
  always_comb begin
    is_mul = md_op == MD_MULT || md_op == MD_MULTU;
    is_div = md_op == MD_DIV || md_op == MD_DIVU;
    ea = {{32{src_a[31]}}, src_a};
    eb = {{32{src_b[31]}}, src_b};
    smul = ea * eb;
    umul = {32'd0, src_a} * {32'd0, src_b};
    dv = src_b == 32'd0 ? 32'd1 : src_b;
    ds = (src_a == 32'h8000_0000 && src_b == 32'hffff_ffff) ? 32'd1 : dv;
    sq = $signed(src_a) / $signed(ds);
    sr = $signed(src_a) % $signed(ds);
    uq = src_a / dv;
    ur = src_a % dv;
    res_hi = md_op == MD_MULT ? smul[63:32] : md_op == MD_MULTU ? umul[63:32] :
             md_op == MD_DIV ? sr : ur;
    res_lo = md_op == MD_MULT ? smul[31:0] : md_op == MD_MULTU ? umul[31:0] :
             md_op == MD_DIV ? sq : uq;
  end
  always_ff @(posedge clk)
    if (reset) begin
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= !(is_div && src_b == 32'd0);
      cnt <= is_mul ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
    end else if (busy) begin
      cnt <= cnt - 16'd1;
      if (cnt == 16'd1 && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else begin
      if (md_op == MD_MTHI) hi <= src_a;
      if (md_op == MD_MTLO) lo <= src_a;
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed + random self-checking bench for md_unit
module tb_md_unit;
  import md_pkg::*;
  logic clk = 0, reset = 1;
  logic [3:0] md_op = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic start, busy;
  logic [31:0] hi, lo, md_out;
  logic [31:0] hi_m = 0, lo_m = 0;
  int errors = 0, checks = 0;
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (op == MD_MULT) begin
      p = sa * sb;
      hi_m = p[63:32];
      lo_m = p[31:0];
    end else if (op == MD_MULTU) begin
      up = ua * ub;
      hi_m = up[63:32];
      lo_m = up[31:0];
    end else if (op == MD_DIV && b != 0) begin
      q = sa / sb;
      r = sa % sb;
      hi_m = r[31:0];
      lo_m = q[31:0];
    end else if (op == MD_DIVU && b != 0) begin
      up = ua / ub;
      hi_m = up[31:0];
      up = ua % ub;
      lo_m = hi_m;
      hi_m = up[31:0];
    end
  endtask
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
    md_op = op;
    src_a = a;
    src_b = b;
    #1;
    chk("start_issue", {31'd0, start}, 32'd1);
    model(op, a, b);
    step();
    md_op = MD_NONE;
    for (int i = 0; i < n; i++) begin
      chk("busy_high", {31'd0, busy}, 32'd1);
      chk("start_low", {31'd0, start}, 32'd0);
      step();
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi", hi, hi_m);
    chk("lo", lo, lo_m);
  endtask
  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    md_op = op;
    src_a = a;
    step();
    if (op == MD_MTHI) hi_m = a;
    else lo_m = a;
    md_op = MD_NONE;
  endtask
  task automatic mf();
    md_op = MD_MFHI;
    #1;
    chk("mfhi", md_out, hi_m);
    md_op = MD_MFLO;
    #1;
    chk("mflo", md_out, lo_m);
    md_op = MD_NONE;
    #1;
    chk("md_out_none", md_out, 32'd0);
  endtask
  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    step();
    step();
    reset = 0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFF1);
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_lo_const", lo, 32'h0000_0001);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    mt(MD_MTHI, 32'h1234);
    mt(MD_MTLO, 32'h5678);
    do_op(MD_DIVU, 32'd7, 32'd0);
    chk("div0_hi_const", hi, 32'h1234);
    chk("div0_lo_const", lo, 32'h5678);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lo_const", lo, 32'h8000_0000);
    chk("ovf_hi_const", hi, 32'h0);
    mt(MD_MTHI, 32'hCAFE_BABE);
    md_op = MD_MFHI;
    #1;
    chk("mfhi_after_mthi", md_out, 32'hCAFE_BABE);
    md_op = MD_NONE;
    // MULT issued; MULTU in busy cycles 2-4 and MTLO in cycle 5 must be ignored
    md_op = MD_MULT;
    src_a = 32'd1000;
    src_b = 32'hFFFF_FF00;
    model(MD_MULT, 32'd1000, 32'hFFFF_FF00);
    step();
    md_op = MD_NONE;
    step();
    for (int i = 2; i <= 4; i++) begin
      md_op = MD_MULTU;
      src_a = 32'd2;
      src_b = 32'd3;
      #1;
      chk("ign_start", {31'd0, start}, 32'd0);
      chk("ign_busy", {31'd0, busy}, 32'd1);
      step();
    end
    md_op = MD_MTLO;
    src_a = 32'hDEAD_BEEF;
    #1;
    chk("mtlo_busy", {31'd0, busy}, 32'd1);
    step();
    md_op = MD_NONE;
    chk("ign_hi", hi, hi_m);
    chk("ign_lo", lo, lo_m);
    do_op(MD_MULT, 32'd7, 32'd6);
    // reset in busy cycle 3 discards the op
    md_op = MD_MULT;
    src_a = 32'd123;
    src_b = 32'd456;
    step();
    md_op = MD_NONE;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    hi_m = 0;
    lo_m = 0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("no_late_hi", hi, 32'd0);
    chk("no_late_lo", lo, 32'd0);
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if (op <= 4) do_op(op, a, b);
      else if (op <= 6) mt(op, a);
      else mf();
    end
    mf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It consumes the forwarded EX operands (post-forwarding-mux rs/rt values) and runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. It owns the HI/LO architectural registers and serves MTHI/MTLO/MFHI/MFLO. It exports `start`/`busy` so the hazard unit can stall D-stage mult/div-class instructions.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of MULT/MULTU (≥1)
- `DIV_CYCLES`, 10, busy duration of DIV/DIVU (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `md_op`  in  4  EX-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NONE
- `src_a`  in  32  forwarded rs value
- `src_b`  in  32  forwarded rt value
- `start`  out  1  combinational: `md_op` ∈ {1..4} and `busy`=0
- `busy`  out  1  registered: operation in flight
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `md_out`  out  32  combinational: `hi` when `md_op`=MFHI, `lo` when MFLO, else 0

## Operation
- Reset (sync): `hi`=`lo`=0, `busy`=0, counter=0, pending results cleared. Outputs after reset: `start`/`md_out` purely combinational from `md_op`.
- Issue (`start`=1 at edge): compute the full result that cycle from `src_a`/`src_b` and latch it into `pend_hi`/`pend_lo`. Load counter with MULT_CYCLES or DIV_CYCLES, and set `busy`.
- MULT: signed 32×32→64; `hi`=[63:32], `lo`=[31:0]. MULTU: unsigned.
- DIV: signed; `lo`=quotient truncated toward zero, `hi`=remainder with the sign of the dividend. DIVU: unsigned.
- 0x80000000 / 0xFFFFFFFF (DIV) → `lo`=0x80000000, `hi`=0.
- Divisor 0: `hi`/`lo` unchanged at commit; busy timing identical to a normal divide.
- Busy: counter decrements each cycle. On the edge where counter==1, commit pending → `hi`/`lo` and clear `busy`.
- MTHI/MTLO with `busy`=0: `hi`/`lo` ← `src_a` at that edge.
- Any `md_op` while `busy`=1 is ignored: no new issue, no MT write. The hazard unit is responsible for not presenting such ops.
- MFHI/MFLO while busy return the stale value. No forwarding of pending results.
- FSM: IDLE (`busy`=0) → BUSY on `start`. BUSY → IDLE on counter==1 (commit). reset → IDLE from any state, discarding the in-flight op.

## Timing
- Issue at cycle 0 edge ⇒ `busy`=1 during cycles 1..N (N = MULT_CYCLES or DIV_CYCLES). New `hi`/`lo` visible and `busy`=0 from cycle N+1.
- `start` and `busy` are never both 1.
- Back-to-back: a new issue is accepted in cycle N+1, the first cycle with `busy`=0.
- MTHI/MTLO: visible on `hi`/`lo` the cycle after the edge. MFHI in that same next cycle reads the new value.
- Reset asserted mid-op: next cycle `busy`=0, `hi`=`lo`=0. No late commit.
- Width: products computed at 64 bits. Operands sign/zero-extended per op before multiply/divide.

## Structure
- Shared package `md_pkg`: `md_op` encodings (MD_NONE…MD_MFLO), default MULT_CYCLES/DIV_CYCLES constants, 4-bit op width. The hazard unit and controller import the same constants.
- Single module, no sub-module. Arithmetic uses synthesizable `*`, `/`, `%` on signed/unsigned casts, with a `busy`/counter control block.

## Test plan
- MULT src_a=0xFFFFFFFD (−3), src_b=5 → `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. DIV −7/2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- With `hi`=0x1234, `lo`=0x5678, DIVU 7/0 → `busy` 10 cycles, then `hi`/`lo` still 0x1234/0x5678. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0xCAFEBABE, then next cycle MFHI → `md_out`=0xCAFEBABE. MTLO issued during BUSY → `lo` unchanged.
- MULT issued, MULTU 2×3 presented in busy cycles 2–4 → ignored, `start`=0 throughout. Second MULT issued in cycle 6 accepted.
- MULT issued, `reset` in busy cycle 3 → next cycle `busy`=0, `hi`=`lo`=0, and no commit afterwards.
